// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and defaults for the video RAM arbiter
// Contents: default widths, CPU FSM state encoding, tag pipeline owner tags.
package vram_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  // Wait counter width and its saturation value
  localparam int            WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    FLIGHT = 2'd2,
    ACK    = 2'd3
  } cpu_state_e;

  typedef enum logic {
    TAG_VID = 1'b0,
    TAG_CPU = 1'b1
  } tag_owner_e;

  typedef struct packed {
    logic       valid;
    tag_owner_e owner;
  } tag_t;

endpackage

// File: rtl/vram_if.sv
// rtl/vram_if.sv - video, CPU and RAM port bundle of the video RAM arbiter
// Ports (signals): vid_rd/vid_addr/vid_dout video fetch; cpu_req/we/be/addr/wdata/ack/rdata
// CPU handshake; ram_addr/we/be/din/dout RAM macro port; starve flag.
// Modports: slave = arbiter side, master = surrounding video/CPU/RAM side.
interface vram_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);

  logic              vid_rd;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_dout;

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [1:0]        ram_be;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              starve;

  modport slave (
    input  vid_rd, vid_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, ram_dout,
    output vid_dout, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_din, starve
  );

  modport master (
    output vid_rd, vid_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, ram_dout,
    input  vid_dout, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_din, starve
  );

endinterface

// File: rtl/vram_tag_pipe.sv
// rtl/vram_tag_pipe.sv - RAM_LAT-deep {valid, owner} shift register tracking RAM reads
// Ports: clk, resetn (sync, active low); push/push_owner enter a read issued this cycle;
// exit_vid/exit_cpu flag that ram_dout now carries data for that owner.
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  tag_owner_e push_owner,
  output logic       exit_vid,
  output logic       exit_cpu
);

  tag_t pipe_q [RAM_LAT];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= tag_t'{valid: 1'b0, owner: TAG_VID};
      end
    end else begin
      pipe_q[0] <= tag_t'{valid: push, owner: push_owner};
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The last stage lines up with the cycle the RAM presents the read data
  assign exit_vid = pipe_q[RAM_LAT-1].valid && (pipe_q[RAM_LAT-1].owner == TAG_VID);
  assign exit_cpu = pipe_q[RAM_LAT-1].valid && (pipe_q[RAM_LAT-1].owner == TAG_CPU);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM shared by video fetch (priority) and CPU
// Ports: clk, resetn (sync, active low), bus (vram_if.slave): video read strobe/data,
// CPU req/ack command port, RAM macro port, sticky CPU starvation flag.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic  clk,
  input  logic  resetn,
  vram_if.slave bus
);

  cpu_state_e state_q, state_d;

  // CPU command captured on acceptance; later input changes are ignored
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [1:0]        cmd_be;
  logic [DATA_W-1:0] cmd_wdata;

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              starve_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vid_dout_q;

  logic              push;
  tag_owner_e        push_owner;
  logic              exit_vid;
  logic              exit_cpu;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [1:0]        ram_be;
  logic [DATA_W-1:0] ram_din;
  logic              cpu_ack;

  vram_tag_pipe #(.RAM_LAT(RAM_LAT)) u_tag_pipe (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_owner (push_owner),
    .exit_vid   (exit_vid),
    .exit_cpu   (exit_cpu)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Port mux and CPU FSM. Video always wins the port; the CPU only drives it
  // from PEND in a cycle with no video strobe, so the two never collide.
  always_comb begin
    state_d    = state_q;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_be     = 2'b00;
    ram_din    = '0;
    push       = 1'b0;
    push_owner = TAG_VID;
    cpu_ack    = 1'b0;

    if (bus.vid_rd) begin
      ram_addr   = bus.vid_addr;
      ram_be     = 2'b11;
      push       = 1'b1;
      push_owner = TAG_VID;
    end else if (state_q == PEND) begin
      ram_addr   = cmd_addr;
      ram_we     = cmd_we;
      ram_be     = cmd_be;
      ram_din    = cmd_wdata;
      push       = !cmd_we;
      push_owner = TAG_CPU;
    end

    case (state_q)
      IDLE:    if (bus.cpu_req) state_d = PEND;
      PEND:    if (!bus.vid_rd) state_d = cmd_we ? ACK : FLIGHT;
      FLIGHT:  if (exit_cpu) state_d = ACK;
      ACK: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_addr    <= '0;
      cmd_we      <= 1'b0;
      cmd_be      <= 2'b00;
      cmd_wdata   <= '0;
      wait_cnt    <= '0;
      starve_q    <= 1'b0;
      cpu_rdata_q <= '0;
      vid_dout_q  <= '0;
    end else begin
      if (state_q == IDLE && bus.cpu_req) begin
        cmd_addr  <= bus.cpu_addr;
        cmd_we    <= bus.cpu_we;
        cmd_be    <= bus.cpu_be;
        cmd_wdata <= bus.cpu_wdata;
        wait_cnt  <= '0;
      end
      if (state_q == PEND && bus.vid_rd) begin
        wait_cnt <= wait_inc;
        if (wait_inc >= WAIT_W'(STARVE_LIMIT)) starve_q <= 1'b1;
      end
      if (state_q == FLIGHT && exit_cpu) cpu_rdata_q <= bus.ram_dout;
      if (exit_vid) vid_dout_q <= bus.ram_dout;
    end
  end

  assign bus.ram_addr  = ram_addr;
  assign bus.ram_we    = ram_we;
  assign bus.ram_be    = ram_be;
  assign bus.ram_din   = ram_din;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_dout  = vid_dout_q;
  assign bus.starve    = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard testbench for vram_arbiter with a 1-cycle RAM model
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int SL  = 16;

  typedef struct {
    logic          is_read;
    logic [DW-1:0] data;
    int            ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // RAM model with a backdoor preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  vram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.ram_we) begin
      if (bus.ram_be[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
      if (bus.ram_be[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
    end
    rd_q <= mem[bus.ram_addr];
  end
  assign bus.ram_dout = rd_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  // Drive a CPU request in the current cycle and record what the ack must look like
  task automatic cpu_start(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_data, input int lat);
    exp_t e;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_be = be;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
    e.is_read = !we; e.data = exp_data; e.ack_cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int budget, output bit got, output int at, output logic [DW-1:0] rd);
    got = 1'b0; at = -1; rd = '0;
    for (int i = 0; i < budget; i++) begin
      if (bus.cpu_ack === 1'b1) begin
        got = 1'b1; at = cyc; rd = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        tick;
        return;
      end
      tick;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.vid_rd = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = 2'b00;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    tick; tick;
    resetn = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_cpu: ack=%b rdata=%h, required 0/0000", bus.cpu_ack, bus.cpu_rdata);
    end
    n_checks++;
    if (bus.vid_dout !== 16'h0 || bus.starve !== 1'b0) begin
      n_fail++; $display("FAIL reset_vid_starve: vid_dout=%h starve=%b, required 0000/0", bus.vid_dout, bus.starve);
    end
    n_checks++;
    if (bus.ram_addr !== 14'h0 || bus.ram_we !== 1'b0 || bus.ram_be !== 2'b00) begin
      n_fail++; $display("FAIL reset_ram: addr=%h we=%b be=%b, required 0/0/00", bus.ram_addr, bus.ram_we, bus.ram_be);
    end
  endtask

  task automatic test_cpu_read;
    bit got; int at; logic [DW-1:0] rd; exp_t e;
    cpu_start(1'b0, 2'b11, 14'h0100, 16'h0, 16'hBEEF, 3);
    tick;
    n_checks++;
    if (bus.ram_addr !== 14'h0100 || bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL read_issue: ram_addr=%h ram_we=%b, required 0100/0", bus.ram_addr, bus.ram_we);
    end
    wait_ack(10, got, at, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || at != e.ack_cyc) begin
      n_fail++; $display("FAIL read_ack_cycle: got=%0d at=%0d, required at=%0d", got, at, e.ack_cyc);
    end
    n_checks++;
    if (rd !== e.data) begin
      n_fail++; $display("FAIL read_data: %h, required %h", rd, e.data);
    end
    n_checks++;
    if (bus.cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_pulse: ack=%b one cycle after ack, required 0", bus.cpu_ack);
    end
  endtask

  task automatic test_vid_priority;
    bit got; int at; logic [DW-1:0] rd; exp_t e;
    cpu_start(1'b0, 2'b11, 14'h0100, 16'h0, 16'hBEEF, 5);
    tick;
    bus.vid_rd = 1'b1; bus.vid_addr = 14'h0200;
    #1;
    n_checks++;
    if (bus.ram_addr !== 14'h0200 || bus.ram_we !== 1'b0 || bus.ram_be !== 2'b11) begin
      n_fail++; $display("FAIL vid_mux: addr=%h we=%b be=%b, required 0200/0/11", bus.ram_addr, bus.ram_we, bus.ram_be);
    end
    tick;
    tick;
    bus.vid_rd = 1'b0;
    #1;
    n_checks++;
    if (bus.ram_addr !== 14'h0100) begin
      n_fail++; $display("FAIL prio_cpu_issue: ram_addr=%h, required 0100", bus.ram_addr);
    end
    n_checks++;
    if (bus.vid_dout !== 16'h5A5A) begin
      n_fail++; $display("FAIL prio_vid_dout: %h, required 5a5a", bus.vid_dout);
    end
    wait_ack(10, got, at, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || at != e.ack_cyc || rd !== e.data) begin
      n_fail++; $display("FAIL prio_ack: got=%0d at=%0d rd=%h, required at=%0d rd=%h", got, at, rd, e.ack_cyc, e.data);
    end
  endtask

  task automatic test_byte_write;
    bit got; int at; logic [DW-1:0] rd; exp_t e;
    cpu_start(1'b1, 2'b10, 14'h0010, 16'h12AB, 16'h0, 2);
    tick;
    n_checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_be !== 2'b10 || bus.ram_addr !== 14'h0010 || bus.ram_din !== 16'h12AB) begin
      n_fail++; $display("FAIL write_issue: we=%b be=%b addr=%h din=%h, required 1/10/0010/12ab",
                         bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_din);
    end
    wait_ack(10, got, at, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || at != e.ack_cyc) begin
      n_fail++; $display("FAIL write_ack_cycle: got=%0d at=%0d, required at=%0d", got, at, e.ack_cyc);
    end
    cpu_start(1'b0, 2'b11, 14'h0010, 16'h0, 16'h1266, 3);
    tick;
    wait_ack(10, got, at, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || at != e.ack_cyc || rd !== e.data) begin
      n_fail++; $display("FAIL write_readback: got=%0d at=%0d rd=%h, required at=%0d rd=%h", got, at, rd, e.ack_cyc, e.data);
    end
  endtask

  task automatic test_starve;
    bit got; int at; logic [DW-1:0] rd; exp_t e;
    n_checks++;
    if (bus.starve !== 1'b0) begin
      n_fail++; $display("FAIL starve_initial: %b, required 0", bus.starve);
    end
    cpu_start(1'b0, 2'b11, 14'h0100, 16'h0, 16'hBEEF, 23);
    tick;
    bus.vid_rd = 1'b1; bus.vid_addr = 14'h0200;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (k == 16) begin
        n_checks++;
        if (bus.starve !== 1'b0) begin
          n_fail++; $display("FAIL starve_early: %b after 15 waits, required 0", bus.starve);
        end
      end
      if (k == 17) begin
        n_checks++;
        if (bus.starve !== 1'b1) begin
          n_fail++; $display("FAIL starve_rise: %b after 16 waits, required 1", bus.starve);
        end
      end
      tick;
    end
    bus.vid_rd = 1'b0;
    wait_ack(10, got, at, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || at != e.ack_cyc || rd !== e.data) begin
      n_fail++; $display("FAIL starve_ack: got=%0d at=%0d rd=%h, required at=%0d rd=%h", got, at, rd, e.ack_cyc, e.data);
    end
    n_checks++;
    if (bus.starve !== 1'b1) begin
      n_fail++; $display("FAIL starve_sticky: %b, required 1", bus.starve);
    end
  endtask

  task automatic test_reset_flight;
    bit seen_ack;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_be = 2'b11; bus.cpu_addr = 14'h0010;
    tick;
    bus.cpu_req = 1'b0;
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 16'h0 || bus.vid_dout !== 16'h0 || bus.starve !== 1'b0) begin
      n_fail++; $display("FAIL flight_reset_out: ack=%b rdata=%h vid=%h starve=%b, required all 0",
                         bus.cpu_ack, bus.cpu_rdata, bus.vid_dout, bus.starve);
    end
    n_checks++;
    if (bus.ram_addr !== 14'h0 || bus.ram_we !== 1'b0 || bus.ram_be !== 2'b00 || bus.ram_din !== 16'h0) begin
      n_fail++; $display("FAIL flight_reset_ram: addr=%h we=%b be=%b din=%h, required all 0",
                         bus.ram_addr, bus.ram_we, bus.ram_be, bus.ram_din);
    end
    seen_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_ack !== 1'b0) seen_ack = 1'b1;
      tick;
    end
    n_checks++;
    if (seen_ack) begin
      n_fail++; $display("FAIL flight_dropped: ack seen=1 after reset, required 0");
    end
  endtask

  task automatic test_vid_hold;
    bit got; int at; logic [DW-1:0] rd; exp_t e;
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    addrs[0] = 14'h0100; datas[0] = 16'hBEEF;
    addrs[1] = 14'h0200; datas[1] = 16'h5A5A;
    addrs[2] = 14'h0010; datas[2] = 16'h1266;
    bus.vid_rd = 1'b1; bus.vid_addr = 14'h0300;
    tick;
    bus.vid_rd = 1'b0;
    tick;
    n_checks++;
    if (bus.vid_dout !== 16'hCAFE) begin
      n_fail++; $display("FAIL hold_load: vid_dout=%h, required cafe", bus.vid_dout);
    end
    for (int n = 0; n < 3; n++) begin
      cpu_start(1'b0, 2'b11, addrs[n], 16'h0, datas[n], 3);
      tick;
      wait_ack(10, got, at, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || at != e.ack_cyc || rd !== e.data) begin
        n_fail++; $display("FAIL hold_cpu_read%0d: got=%0d at=%0d rd=%h, required at=%0d rd=%h",
                           n, got, at, rd, e.ack_cyc, e.data);
      end
      n_checks++;
      if (bus.vid_dout !== 16'hCAFE) begin
        n_fail++; $display("FAIL hold_vid_dout%0d: %h, required cafe", n, bus.vid_dout);
      end
    end
  endtask

  initial begin
    test_reset;
    preload(14'h0100, 16'hBEEF);
    preload(14'h0200, 16'h5A5A);
    preload(14'h0010, 16'h5566);
    preload(14'h0300, 16'hCAFE);
    test_cpu_read;
    test_vid_priority;
    test_byte_write;
    test_starve;
    test_reset_flight;
    test_vid_hold;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (2^ADDR_W words of 16 bits) between the raster video fetch engine and the CPU bus interface.
- The video engine issues one-cycle read strobes at fixed points in its pixel timing and has absolute priority. The CPU gets every remaining cycle through a req/ack handshake.
- The block sits between the video generator, the CPU memory decoder and the RAM macro. It also reports CPU starvation.

Parameters:
ADDR_W, 14, word address width (vid/cpu/ram addresses, bits [14:1] of byte address)
DATA_W, 16, RAM word width
RAM_LAT, 1, RAM read latency in cycles, allowed 1..3
STARVE_LIMIT, 16, CPU wait cycles in PEND that set the starve flag, allowed 1..255

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active low
vid_rd  in  1  video read strobe, one cycle per word
vid_addr  in  ADDR_W  video word address, valid with vid_rd
vid_dout  out  DATA_W  last video read data, held
cpu_req  in  1  CPU request level, held until cpu_ack
cpu_we  in  1  1 = write
cpu_be  in  2  byte enables, [1] = upper byte
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high, held afterwards
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_be  out  2  RAM byte enables
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data, RAM_LAT cycles after address
starve  out  1  sticky CPU starvation flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn; it is sampled on the clk edge.
- Reset values:
  - State is IDLE.
  - cpu_ack=0, cpu_rdata=0, vid_dout=0, starve=0.
  - Wait counter=0, tag pipeline cleared.
- Reset mid-operation: any pending or in-flight CPU access is dropped with no ack. The RAM contents are not touched.
- Port mux, combinational:
  - vid_rd=1 → ram_addr=vid_addr, ram_we=0, ram_be=2'b11.
  - Else, in state PEND → ram_addr, ram_we, ram_be and ram_din come from the latched CPU command.
  - Otherwise → ram_we=0, ram_be=0, ram_addr=0.
- Tag pipeline: RAM_LAT-deep shift register of {valid, owner}, owner is VID or CPU.
  - A write does not enter the pipeline.
  - When the tag exits as VID → vid_dout<=ram_dout.
  - vid_dout is not disturbed by CPU reads.
- CPU FSM:
  - IDLE: when cpu_req=1, latch addr/we/be/wdata, clear the wait counter, go to PEND.
  - PEND, vid_rd=1: stay. Wait counter increments, saturating at 255. When it reaches STARVE_LIMIT, starve<=1 (sticky until reset).
  - PEND, vid_rd=0: issue the command on the RAM port this cycle. A write goes to ACK. A read pushes a CPU tag and goes to FLIGHT.
  - FLIGHT: when the CPU tag exits, cpu_rdata<=ram_dout and go to ACK.
  - ACK: cpu_ack=1 for exactly one cycle, then go to IDLE. The requester must have cpu_req low by the cycle after ACK, otherwise a new request is taken.
- Timing with RAM_LAT=1 and req sampled in cycle T:
  - Read: issue at T+1, ack at T+3.
  - Write: issue at T+1, ack at T+2.
  - Each cycle of vid_rd during PEND adds one cycle.
- Simultaneous events:
  - vid_rd while the CPU is in FLIGHT is legal; the port is already free.
  - vid_rd and a CPU issue can never share a cycle.
  - cpu_req while not in IDLE is ignored.
  - Input changes after the latch are ignored.
- Address wrap: none; addresses are used as given, full ADDR_W.

Decomposition:
- Package vram_pkg holds:
  - ADDR_W and DATA_W defaults
  - CPU FSM state encoding: IDLE, PEND, FLIGHT, ACK
  - owner tag constants: TAG_VID, TAG_CPU
- One sub-module: vram_tag_pipe. It is the RAM_LAT-deep {valid, owner} shift register with an exit strobe per owner.

Test Plan:
- CPU read, idle video: mem[0x0100]=0xBEEF, cpu_req at T → ram_addr=0x0100 at T+1; cpu_ack at T+3 with cpu_rdata=0xBEEF.
- Video priority: vid_rd=1 with vid_addr=0x0200 at T+1 and T+2, CPU read 0x0100 requested at T → CPU issues at T+3, ack at T+5. vid_dout=mem[0x0200] from T+3.
- Byte write: cpu_we=1, be=2'b10, addr 0x0010, wdata 0x12AB over 0x5566 → ram_we=1 and ram_be=2'b10 at T+1, ack at T+2. A subsequent read returns 0x1266.
- Starvation, STARVE_LIMIT=16: vid_rd held high 20 cycles during PEND → starve rises after the 16th wait cycle and stays high after the CPU completes.
- Reset mid-FLIGHT: resetn=0 for one cycle while in FLIGHT → no cpu_ack is ever produced, and all outputs are 0 the next cycle.
- vid_dout hold: video read 0x0300=0xCAFE, then three CPU reads of other addresses → vid_dout stays 0xCAFE throughout.
